// File: rtl/onehot_decoder_acc_if.sv
// Handshake bundle for the one-hot decoder: input index beats and decoded output words.
// Purely structural; no storage, no latency.
// Backpressure is carried by in_ready (input side) and out_ready (output side).
interface onehot_decoder_acc_if #(
    parameter int N_OUT = 32,
    parameter int IDX_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [IDX_W-1:0] in_idx;
    logic             in_zero;
    logic             in_acc;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [N_OUT-1:0] out_y;
    logic             out_err;

    // Producer of index beats / consumer of decoded words
    modport master (
        output in_valid, in_idx, in_zero, in_acc, in_last, out_ready,
        input  in_ready, out_valid, out_y, out_err
    );

    // The decoder itself
    modport slave (
        input  in_valid, in_idx, in_zero, in_acc, in_last, out_ready,
        output in_ready, out_valid, out_y, out_err
    );
endinterface

// File: rtl/onehot_decoder_acc.sv
// Binary index -> one-hot decoder with optional OR-accumulation of several beats into one mask.
// Latency: one cycle from accepting the closing beat of a word to out_valid.
// Backpressure: in_ready = en & (not holding | out_ready); output held stable until taken.
module onehot_decoder_acc #(
    parameter int N_OUT = 32,
    parameter int IDX_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    onehot_decoder_acc_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [N_OUT-1:0] ONE = N_OUT'(1);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             in_range;
    logic [N_OUT-1:0] oh;
    logic             beat_err;
    logic [N_OUT-1:0] mask;
    logic             acc_err;
    logic             word_start;
    logic             opens_accum;

    // When the index space is fully populated every index is in range,
    // so the comparison is only built when some indices are unused.
    if (N_OUT >= (1 << IDX_W)) begin : g_full_range
        assign in_range = 1'b1;
    end else begin : g_part_range
        localparam logic [IDX_W:0] N_OUT_W = (IDX_W+1)'(N_OUT);
        assign in_range = ({1'b0, bus.in_idx} < N_OUT_W);
    end

    // Per-beat decode: an empty beat contributes nothing, an out-of-range index
    // contributes nothing but flags the word.
    always_comb begin
        oh       = '0;
        beat_err = 1'b0;
        if (!bus.in_zero) begin
            if (in_range) begin
                oh = ONE << bus.in_idx;
            end else begin
                beat_err = 1'b1;
            end
        end
    end

    assign accept      = bus.in_valid & bus.in_ready;
    // A beat arriving in IDLE, or in HOLD while the held word drains, starts a new word.
    assign word_start  = accept & (state != ACCUM);
    assign opens_accum = bus.in_acc & ~bus.in_last;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = opens_accum ? ACCUM : HOLD;
                end
            end
            ACCUM: begin
                if (accept && bus.in_last) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    if (accept) begin
                        state_nxt = opens_accum ? ACCUM : HOLD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs; in HOLD a new beat is only taken when the held word leaves the same cycle
    always_comb begin
        bus.in_ready  = en & ((state != HOLD) | bus.out_ready);
        bus.out_valid = (state == HOLD);
    end

    // Accumulator and registered output word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask        <= '0;
            acc_err     <= 1'b0;
            bus.out_y   <= '0;
            bus.out_err <= 1'b0;
        end else begin
            if (word_start) begin
                if (opens_accum) begin
                    mask    <= oh;
                    acc_err <= beat_err;
                end else begin
                    mask        <= '0;
                    acc_err     <= 1'b0;
                    bus.out_y   <= oh;
                    bus.out_err <= beat_err;
                end
            end else if (accept) begin
                // Mid-word beat; in_acc is irrelevant once accumulating
                if (bus.in_last) begin
                    bus.out_y   <= mask | oh;
                    bus.out_err <= acc_err | beat_err;
                    mask        <= '0;
                    acc_err     <= 1'b0;
                end else begin
                    mask    <= mask | oh;
                    acc_err <= acc_err | beat_err;
                end
            end else if (state == HOLD && bus.out_ready) begin
                mask    <= '0;
                acc_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_onehot_decoder_acc.sv
// Directed bench for onehot_decoder_acc: full 32-line instance plus a 24-line instance
// for out-of-range indices. Inputs driven 1 time unit after the rising edge,
// outputs sampled on the falling edge.
module tb_onehot_decoder_acc;

    logic clk;
    logic rst_n;
    logic en;
    logic en2;

    int n_tests;
    int n_fail;

    onehot_decoder_acc_if #(.N_OUT(32), .IDX_W(5)) bus ();
    onehot_decoder_acc_if #(.N_OUT(24), .IDX_W(5)) bus2 ();

    onehot_decoder_acc #(.N_OUT(32), .IDX_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .bus   (bus.slave)
    );

    onehot_decoder_acc #(.N_OUT(24), .IDX_W(5)) dut24 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en2),
        .bus   (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Offer one beat to the 32-line instance starting just after a rising edge;
    // returns just after the edge on which it was accepted.
    task automatic send(input logic [4:0] idx, input logic zero, input logic acc, input logic last);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_idx   = idx;
        bus.in_zero  = zero;
        bus.in_acc   = acc;
        bus.in_last  = last;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Same for the 24-line instance
    task automatic send24(input logic [4:0] idx);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        bus2.in_valid = 1'b1;
        bus2.in_idx   = idx;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus2.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout24", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus2.in_valid = 1'b0;
    endtask

    initial begin
        logic [4:0]  idx_tab [3];
        logic [31:0] exp_tab [3];
        idx_tab = '{5'd0, 5'd5, 5'd31};
        exp_tab = '{32'h0000_0001, 32'h0000_0020, 32'h8000_0000};

        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        en      = 1'b1;
        en2     = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_idx    = '0;
        bus.in_zero   = 1'b0;
        bus.in_acc    = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        bus2.in_valid  = 1'b0;
        bus2.in_idx    = '0;
        bus2.in_zero   = 1'b0;
        bus2.in_acc    = 1'b0;
        bus2.in_last   = 1'b0;
        bus2.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_y",     bus.out_y, 32'd0);
        check("rst_out_err",   {31'd0, bus.out_err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // 1: single beats, one cycle accept-to-valid
        for (int k = 0; k < 3; k++) begin
            send(idx_tab[k], 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            check("single_valid", {31'd0, bus.out_valid}, 32'd1);
            check("single_y",     bus.out_y, exp_tab[k]);
            check("single_err",   {31'd0, bus.out_err}, 32'd0);
        end
        @(posedge clk);
        @(negedge clk);
        check("drain_valid", {31'd0, bus.out_valid}, 32'd0);

        // 2: accumulate 3,3,17, last 31
        send(5'd3, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("acc_no_valid0", {31'd0, bus.out_valid}, 32'd0);
        send(5'd3, 1'b0, 1'b1, 1'b0);
        send(5'd17, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("acc_no_valid2", {31'd0, bus.out_valid}, 32'd0);
        send(5'd31, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check("acc_valid", {31'd0, bus.out_valid}, 32'd1);
        check("acc_y",     bus.out_y, 32'h8002_0008);
        check("acc_err",   {31'd0, bus.out_err}, 32'd0);

        // 3: empty beat, then out-of-range and top-index on the 24-line instance
        send(5'd9, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("zero_valid", {31'd0, bus.out_valid}, 32'd1);
        check("zero_y",     bus.out_y, 32'd0);
        check("zero_err",   {31'd0, bus.out_err}, 32'd0);
        send24(5'd30);
        @(negedge clk);
        check("oor_valid", {31'd0, bus2.out_valid}, 32'd1);
        check("oor_y",     32'(bus2.out_y), 32'd0);
        check("oor_err",   {31'd0, bus2.out_err}, 32'd1);
        send24(5'd23);
        @(negedge clk);
        check("top24_y",   32'(bus2.out_y), 32'h0080_0000);
        check("top24_err", {31'd0, bus2.out_err}, 32'd0);

        // 4: backpressure, then release into 1-per-cycle streaming
        bus.out_ready = 1'b0;
        send(5'd4, 1'b0, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_idx   = 5'd9;
        bus.in_zero  = 1'b0;
        bus.in_acc   = 1'b0;
        bus.in_last  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            check("bp_valid",    {31'd0, bus.out_valid}, 32'd1);
            check("bp_y",        bus.out_y, 32'h0000_0010);
        end
        bus.out_ready = 1'b1;
        #1;
        check("release_in_ready", {31'd0, bus.in_ready}, 32'd1);
        for (int k = 9; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (k < 12) bus.in_idx = 5'(k + 1);
            else        bus.in_valid = 1'b0;
            @(negedge clk);
            check("stream_valid", {31'd0, bus.out_valid}, 32'd1);
            check("stream_y",     bus.out_y, 32'd1 << k);
        end

        // 5: en=0 while accumulating keeps the partial mask
        send(5'd6, 1'b0, 1'b1, 1'b0);
        send(5'd8, 1'b0, 1'b1, 1'b0);
        en = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_idx   = 5'd1;
        bus.in_last  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("en0_in_ready", {31'd0, bus.in_ready}, 32'd0);
            check("en0_valid",    {31'd0, bus.out_valid}, 32'd0);
        end
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        en = 1'b1;
        send(5'd1, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check("en_resume_valid", {31'd0, bus.out_valid}, 32'd1);
        check("en_resume_y",     bus.out_y, 32'h0000_0142);

        // 6: asynchronous reset mid-accumulation discards the partial mask
        send(5'd4, 1'b0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("arst_y",     bus.out_y, 32'd0);
        check("arst_err",   {31'd0, bus.out_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(5'd2, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("post_rst_valid", {31'd0, bus.out_valid}, 32'd1);
        check("post_rst_y",     bus.out_y, 32'h0000_0004);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
